// File: rtl/mux_16_to_1.sv
// -----------------------------------------------------------------------------
// mux_16_to_1
//   Single-bit 16:1 multiplexer used by the FP ALU datapath for operand and
//   shift-bit selection. The combinational result is built as a balanced tree
//   of 2:1 muxes (8 + 4 + 2 + 1 stages, four levels deep). A registered copy is
//   also provided for pipelined consumers.
//
// Ports
//   out    output  1       combinational selected bit, equal to in[sel]
//   in     input   [0:15]  data inputs, ascending range (in[0] is the MSB of
//                          a 16'b literal)
//   sel    input   [0:3]   select, ascending range (sel[0] is the MSB, value
//                          0..15)
//   clk    input   1       rising-edge clock, drives out_q only
//   rst_n  input   1       asynchronous active-low reset, clears out_q only
//   out_q  output  1       out registered on clk (latency 1)
//
// The port order keeps (out, in, sel) first so that older positional
// instances remain valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mux_16_to_1 (
  output logic        out,
  input  logic [0:15] in,
  input  logic [0:3]  sel,
  input  logic        clk,
  input  logic        rst_n,
  output logic        out_q
);

  // Intermediate results of each tree level. Index k of a level is the
  // survivor of the pair (2k, 2k+1) from the level below.
  logic [0:7] lvl1;
  logic [0:3] lvl2;
  logic [0:1] lvl3;

  logic out_sample_d;
  logic out_sample_q;

  // Tree stages use the conditional operator rather than if/case so that an
  // unknown select bit yields X unless both candidates agree.
  // Level 1 is steered by the least significant select bit, sel[3].
  for (genvar k = 0; k < 8; k++) begin : g_lvl1
    assign lvl1[k] = sel[3] ? in[2*k+1] : in[2*k];
  end

  for (genvar k = 0; k < 4; k++) begin : g_lvl2
    assign lvl2[k] = sel[2] ? lvl1[2*k+1] : lvl1[2*k];
  end

  for (genvar k = 0; k < 2; k++) begin : g_lvl3
    assign lvl3[k] = sel[1] ? lvl2[2*k+1] : lvl2[2*k];
  end

  // Final stage is steered by the most significant select bit, sel[0].
  assign out = sel[0] ? lvl3[1] : lvl3[0];

  // Next-state for the pipelined copy is simply the current combinational
  // result; reset only touches the register, never the tree.
  always_comb begin
    out_sample_d = out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sample_q <= 1'b0;
    end else begin
      out_sample_q <= out_sample_d;
    end
  end

  assign out_q = out_sample_q;

endmodule

// File: tb/tb_mux_16_to_1.sv
// -----------------------------------------------------------------------------
// tb_mux_16_to_1
//   Self-checking bench for mux_16_to_1. Expected values come from an
//   arithmetic reference: the selected bit is bit (15 - sel) of the 16-bit
//   input value, where the first element of the ascending input bus is the
//   literal's MSB.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mux_16_to_1;

  logic        out;
  logic [0:15] in_bus;
  logic [0:3]  sel_bus;
  logic        clk;
  logic        rst_n;
  logic        out_q;

  int total;
  int bad;

  mux_16_to_1 dut (
    .out   (out),
    .in    (in_bus),
    .sel   (sel_bus),
    .clk   (clk),
    .rst_n (rst_n),
    .out_q (out_q)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pick bit N counting from the MSB of the literal value.
  function automatic logic ref_mux(input logic [15:0] value, input int n);
    logic [15:0] shifted;
    shifted = value >> (15 - n);
    return shifted[0];
  endfunction

  // Drive the data/select inputs from a plain 16-bit value and select number.
  task automatic apply_stimulus(input logic [15:0] value, input int n);
    in_bus  = value;
    sel_bus = 4'(n);
  endtask

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic check_output(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    logic [15:0] value;
    logic        exp_out;
    int          n;

    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    in_bus  = '0;
    sel_bus = '0;

    // Reset held low while the clock toggles: out_q stays 0 and out keeps
    // following its inputs.
    apply_stimulus(16'h8000, 0);
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_out_q", out_q, 1'b0);
    check_output("reset_out_follows", out, 1'b1);

    // Release reset away from the clock edge, then one edge loads out.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("release_no_edge", out_q, 1'b0);
    @(posedge clk);
    #1;
    check_output("first_edge_out_q", out_q, 1'b1);

    // Asynchronous reset mid-cycle clears out_q at once; out is untouched.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_out_q", out_q, 1'b0);
    check_output("async_reset_out", out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Walking one: only bit N set, select N.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(16'h8000 >> i, i);
      #1;
      check_output($sformatf("walk_one_%0d", i), out, 1'b1);
      #29;
    end

    // Walking zero: bit N cleared selects 0, neighbour selects 1.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(~(16'h8000 >> i), i);
      #1;
      check_output($sformatf("walk_zero_%0d", i), out, 1'b0);
      apply_stimulus(~(16'h8000 >> i), (i + 1) % 16);
      #1;
      check_output($sformatf("walk_zero_next_%0d", i), out, 1'b1);
    end

    // Bit ordering at both ends of the bus.
    apply_stimulus(16'h0001, 15);
    #1;
    check_output("order_sel15", out, 1'b1);
    apply_stimulus(16'h0001, 0);
    #1;
    check_output("order_sel0", out, 1'b0);

    // Select MSB unknown with agreeing candidates in[0] and in[8].
    in_bus  = 16'h8080;
    sel_bus = 4'bx000;
    #1;
    check_output("xsel_agree_one", out, 1'b1);
    in_bus  = 16'h7F7F;
    #1;
    check_output("xsel_agree_zero", out, 1'b0);

    // Randomized inputs on the falling edge; check out immediately and the
    // registered copy after the next rising edge.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      value = 16'($urandom);
      n     = int'($urandom_range(15, 0));
      apply_stimulus(value, n);
      exp_out = ref_mux(value, n);
      #1;
      check_output($sformatf("rand_out_%0d", i), out, exp_out);
      @(posedge clk);
      #1;
      check_output($sformatf("rand_out_q_%0d", i), out_q, exp_out);
    end

    $display("[TB] directed and random phases complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
